// File: rtl/tile_stream_serializer.sv
// Streams one captured tiled vector as LANES-wide beats with per-lane keep and a last flag.
// The beat to present next is precomputed combinationally and loaded into the output registers.
//
// state  | meaning
// IDLE   | ready_in high, waiting for a vector with a non-zero element count
// STREAM | presenting beats of the held vector until the last one is accepted
module tile_stream_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_ELEMS   = 256,
    parameter int LANES      = 16,
    parameter int CNT_W      = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH*IN_ELEMS-1:0] data_in,
    input  logic [CNT_W-1:0]               elem_count,
    input  logic                           valid_in,
    output logic                           ready_in,
    output logic [DATA_WIDTH*LANES-1:0]    data_out,
    output logic [LANES-1:0]               keep_out,
    output logic                           last_out,
    output logic                           valid_out,
    input  logic                           ready_out,
    output logic                           busy
);

    localparam int NBEATS = IN_ELEMS / LANES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                          state_q;
    logic [DATA_WIDTH*IN_ELEMS-1:0]  vec_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [BW-1:0]                   beat_q;
    logic [DATA_WIDTH*LANES-1:0]     data_q;
    logic [LANES-1:0]                keep_q;
    logic                            last_q;
    logic                            valid_q;
    logic                            ready_q;
    logic                            busy_q;

    logic [CNT_W-1:0]                cnt_clamp;
    logic [DATA_WIDTH*IN_ELEMS-1:0]  src_vec;
    logic [CNT_W-1:0]                src_cnt;
    logic [BW-1:0]                   src_idx;
    logic [DATA_WIDTH*IN_ELEMS-1:0]  shifted;
    logic [DATA_WIDTH*LANES-1:0]     data_d;
    logic [LANES-1:0]                keep_d;
    logic                            last_d;

    // In IDLE the candidate beat is beat 0 of the incoming vector, otherwise the successor beat.
    always_comb begin
        cnt_clamp = (elem_count > CNT_W'(IN_ELEMS)) ? CNT_W'(IN_ELEMS) : elem_count;
        if (state_q == S_IDLE) begin
            src_vec = data_in;
            src_cnt = cnt_clamp;
            src_idx = '0;
        end else begin
            src_vec = vec_q;
            src_cnt = cnt_q;
            src_idx = beat_q + BW'(1);
        end
        shifted = src_vec >> (int'(src_idx) * LANES * DATA_WIDTH);
        data_d  = shifted[DATA_WIDTH*LANES-1:0];
        keep_d  = '0;
        for (int l = 0; l < LANES; l++) begin
            keep_d[l] = (int'(src_idx) * LANES + l) < int'(src_cnt);
            if (!keep_d[l]) data_d[l*DATA_WIDTH +: DATA_WIDTH] = '0;
        end
        last_d = ((int'(src_idx) + 1) * LANES) >= int'(src_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A zero-count vector is consumed without leaving IDLE.
                    if (valid_in && (cnt_clamp != '0)) begin
                        vec_q   <= data_in;
                        cnt_q   <= cnt_clamp;
                        beat_q  <= '0;
                        data_q  <= data_d;
                        keep_q  <= keep_d;
                        last_q  <= last_d;
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (ready_out) begin
                        if (last_q) begin
                            data_q  <= '0;
                            keep_q  <= '0;
                            last_q  <= 1'b0;
                            valid_q <= 1'b0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            beat_q  <= src_idx;
                            data_q  <= data_d;
                            keep_q  <= keep_d;
                            last_q  <= last_d;
                        end
                    end
                end
            endcase
        end
    end

    assign ready_in  = ready_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign last_out  = last_q;
    assign valid_out = valid_q;
    assign busy      = busy_q;

endmodule
